// File: rtl/guess_evaluator_if.sv
// Guess handshake and result bundle between the game control unit and one guess_evaluator.
interface guess_evaluator_if #(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 5
);
  logic [LETTER_W-1:0] guessLetter;
  logic                guessValid;
  logic                guessReady;
  logic [WORD_LEN-1:0] revealMask;
  logic [2:0]          guesses;
  logic                lastHit;
  logic                resultValid;
  logic                levelDone;

  modport master (
    output guessLetter, guessValid,
    input  guessReady, revealMask, guesses, lastHit, resultValid, levelDone
  );

  modport slave (
    input  guessLetter, guessValid,
    output guessReady, revealMask, guesses, lastHit, resultValid, levelDone
  );
endinterface

// File: rtl/guess_evaluator.sv
// Per-level letter-guess engine: latches a word, scans each accepted guess serially
// and updates the revealed-letter mask and the saturating wrong-guess count.
module guess_evaluator #(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 5
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         levelStart,
  input  logic [WORD_LEN*LETTER_W-1:0] wordIn,
  guess_evaluator_if.slave             gif
);

  localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SCAN, UPDATE, DONE} state_t;

  state_t              state, stateNext;
  logic                levelStartQ;
  logic [LETTER_W-1:0] letters [WORD_LEN];
  logic [LETTER_W-1:0] letter;
  logic [WORD_LEN-1:0] hit;
  logic [WORD_LEN-1:0] mask;
  logic [WORD_LEN-1:0] maskNext;
  logic [IDX_W-1:0]    index;
  logic [2:0]          guessCount;
  logic                lastHitQ;
  logic                resultValidQ;
  logic                levelDoneQ;
  logic                guessReadyQ;
  logic                accept;

  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Dropping levelStart anywhere outside IDLE abandons the level, overriding every other transition.
  always_comb begin
    stateNext = state;
    accept    = (state == WAIT) && gif.guessValid;
    maskNext  = mask | hit;
    case (state)
      IDLE:    if (levelStart && !levelStartQ) stateNext = LOAD;
      LOAD:    stateNext = WAIT;
      WAIT:    if (accept && (gif.guessLetter != '0)) stateNext = SCAN;
      SCAN:    if (index == IDX_W'(WORD_LEN - 1)) stateNext = UPDATE;
      UPDATE:  stateNext = (&maskNext) ? DONE : WAIT;
      DONE:    stateNext = DONE;
      default: stateNext = IDLE;
    endcase
    if ((state != IDLE) && !levelStart) stateNext = IDLE;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      levelStartQ  <= 1'b0;
      letter       <= '0;
      hit          <= '0;
      index        <= '0;
      mask         <= '0;
      guessCount   <= 3'd0;
      lastHitQ     <= 1'b0;
      resultValidQ <= 1'b0;
      levelDoneQ   <= 1'b0;
      guessReadyQ  <= 1'b0;
      for (int i = 0; i < WORD_LEN; i++) letters[i] <= '0;
    end else begin
      levelStartQ  <= levelStart;
      resultValidQ <= 1'b0;
      guessReadyQ  <= (stateNext == WAIT);
      if (stateNext == IDLE) levelDoneQ <= 1'b0;
      case (state)
        LOAD: begin
          if (levelStart) begin
            for (int i = 0; i < WORD_LEN; i++) letters[i] <= wordIn[i*LETTER_W +: LETTER_W];
            mask       <= '0;
            guessCount <= 3'd0;
            lastHitQ   <= 1'b0;
            levelDoneQ <= 1'b0;
          end
        end
        WAIT: begin
          if (accept) begin
            letter <= gif.guessLetter;
            hit    <= '0;
            index  <= '0;
          end
        end
        SCAN: begin
          hit[index] <= (letters[index] == letter);
          index      <= index + 1'b1;
        end
        UPDATE: begin
          if (levelStart) begin
            mask         <= maskNext;
            lastHitQ     <= |hit;
            resultValidQ <= 1'b1;
            if ((hit == '0) && (guessCount != 3'd7)) guessCount <= guessCount + 3'd1;
            if (&maskNext) levelDoneQ <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gif.guessReady  = guessReadyQ;
  assign gif.revealMask  = mask;
  assign gif.guesses     = guessCount;
  assign gif.lastHit     = lastHitQ;
  assign gif.resultValid = resultValidQ;
  assign gif.levelDone   = levelDoneQ;

endmodule

// File: tb/tb_guess_evaluator.sv
// Directed bench for guess_evaluator: one task per scenario with hand-computed expectations.
module tb_guess_evaluator;

  logic        Clk;
  logic        reset;
  logic        levelStart;
  logic [24:0] wordIn;
  int          checks;
  int          errors;

  guess_evaluator_if #(.WORD_LEN(5), .LETTER_W(5)) gif ();

  guess_evaluator #(.WORD_LEN(5), .LETTER_W(5)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .levelStart (levelStart),
    .wordIn     (wordIn),
    .gif        (gif)
  );

  // Letter 0 sits in the low bits, so the concatenations read back to front.
  localparam logic [24:0] WORD_CABLE = {5'd5, 5'd12, 5'd2, 5'd1, 5'd3};
  localparam logic [24:0] WORD_LEVEL = {5'd12, 5'd5, 5'd22, 5'd5, 5'd12};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic startLevel(input logic [24:0] w);
    levelStart = 1'b0;
    tick();
    wordIn     = w;
    levelStart = 1'b1;
    tick();
    tick();
  endtask

  task automatic doGuess(input logic [4:0] l, input logic [4:0] expMask, input logic [2:0] expGuesses,
                         input logic expHit, input logic expDone);
    int n;
    bit seen;
    gif.guessLetter = l;
    gif.guessValid  = 1'b1;
    tick();
    gif.guessValid  = 1'b0;
    n    = 0;
    seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (gif.resultValid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != 6) begin
      errors++;
      $display("[TB] FAIL latency letter %0d: got %0d cycles (seen=%0d), expected 6", l, n, seen);
    end
    checks++;
    if (gif.revealMask !== expMask) begin
      errors++;
      $display("[TB] FAIL mask letter %0d: got %b, expected %b", l, gif.revealMask, expMask);
    end
    checks++;
    if (gif.guesses !== expGuesses) begin
      errors++;
      $display("[TB] FAIL guesses letter %0d: got %0d, expected %0d", l, gif.guesses, expGuesses);
    end
    checks++;
    if (gif.lastHit !== expHit) begin
      errors++;
      $display("[TB] FAIL lastHit letter %0d: got %b, expected %b", l, gif.lastHit, expHit);
    end
    checks++;
    if (gif.levelDone !== expDone) begin
      errors++;
      $display("[TB] FAIL levelDone letter %0d: got %b, expected %b", l, gif.levelDone, expDone);
    end
    checks++;
    if (gif.guessReady !== !expDone) begin
      errors++;
      $display("[TB] FAIL guessReady letter %0d: got %b, expected %b", l, gif.guessReady, !expDone);
    end
    tick();
    checks++;
    if (gif.resultValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resultPulse letter %0d: got %b, expected 0", l, gif.resultValid);
    end
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    levelStart      = 1'b0;
    wordIn          = '0;
    gif.guessLetter = '0;
    gif.guessValid  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({gif.guessReady, gif.revealMask, gif.guesses, gif.lastHit, gif.resultValid, gif.levelDone} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset outputs: got rdy=%b mask=%b g=%0d hit=%b rv=%b done=%b, expected all 0",
               gif.guessReady, gif.revealMask, gif.guesses, gif.lastHit, gif.resultValid, gif.levelDone);
    end
  endtask

  task automatic test_hit();
    startLevel(WORD_CABLE);
    checks++;
    if (gif.guessReady !== 1'b1 || gif.revealMask !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL load: got rdy=%b mask=%b, expected rdy=1 mask=00000", gif.guessReady, gif.revealMask);
    end
    doGuess(5'd1, 5'b00010, 3'd0, 1'b1, 1'b0);
    doGuess(5'd1, 5'b00010, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_miss_saturate();
    startLevel(WORD_CABLE);
    doGuess(5'd26, 5'b00000, 3'd1, 1'b0, 1'b0);
    doGuess(5'd17, 5'b00000, 3'd2, 1'b0, 1'b0);
    doGuess(5'd26, 5'b00000, 3'd3, 1'b0, 1'b0);
    doGuess(5'd24, 5'b00000, 3'd4, 1'b0, 1'b0);
    doGuess(5'd25, 5'b00000, 3'd5, 1'b0, 1'b0);
    doGuess(5'd23, 5'b00000, 3'd6, 1'b0, 1'b0);
    doGuess(5'd22, 5'b00000, 3'd7, 1'b0, 1'b0);
    doGuess(5'd21, 5'b00000, 3'd7, 1'b0, 1'b0);
  endtask

  task automatic test_zero_guess();
    bit bad;
    startLevel(WORD_CABLE);
    doGuess(5'd1, 5'b00010, 3'd0, 1'b1, 1'b0);
    doGuess(5'd26, 5'b00010, 3'd1, 1'b0, 1'b0);
    gif.guessLetter = 5'd0;
    gif.guessValid  = 1'b1;
    tick();
    gif.guessValid  = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (gif.resultValid !== 1'b0 || gif.guessReady !== 1'b1) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL zeroGuess handshake: saw resultValid or guessReady drop, expected neither");
    end
    checks++;
    if (gif.revealMask !== 5'b00010 || gif.guesses !== 3'd1 || gif.lastHit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zeroGuess outputs: got mask=%b g=%0d hit=%b, expected 00010 1 0",
               gif.revealMask, gif.guesses, gif.lastHit);
    end
    doGuess(5'd2, 5'b00110, 3'd1, 1'b1, 1'b0);
  endtask

  task automatic test_multi_done();
    bit bad;
    startLevel(WORD_LEVEL);
    doGuess(5'd12, 5'b10001, 3'd0, 1'b1, 1'b0);
    doGuess(5'd5,  5'b11011, 3'd0, 1'b1, 1'b0);
    doGuess(5'd22, 5'b11111, 3'd0, 1'b1, 1'b1);
    gif.guessLetter = 5'd7;
    gif.guessValid  = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gif.resultValid !== 1'b0 || gif.guessReady !== 1'b0 || gif.levelDone !== 1'b1) bad = 1;
    end
    gif.guessValid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL doneHold: activity seen in DONE, expected rdy=0 rv=0 done=1");
    end
    levelStart = 1'b0;
    tick();
    checks++;
    if (gif.levelDone !== 1'b0 || gif.revealMask !== 5'b11111) begin
      errors++;
      $display("[TB] FAIL doneExit: got done=%b mask=%b, expected 0 11111", gif.levelDone, gif.revealMask);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int first;
    int second;
    startLevel(WORD_CABLE);
    gif.guessLetter = 5'd3;
    gif.guessValid  = 1'b1;
    tick();
    first  = -1;
    second = -1;
    t      = 0;
    while (second < 0 && t < 40) begin
      tick();
      t++;
      if (gif.resultValid === 1'b1) begin
        if (first < 0) begin
          first = t;
          gif.guessLetter = 5'd2;
          checks++;
          if (gif.revealMask !== 5'b00001 || gif.guessReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2bFirst: got mask=%b rdy=%b, expected 00001 1", gif.revealMask, gif.guessReady);
          end
        end else begin
          second = t;
        end
      end
    end
    gif.guessValid = 1'b0;
    checks++;
    if (second < 0 || second - first != 7) begin
      errors++;
      $display("[TB] FAIL b2bThroughput: got spacing %0d (first=%0d second=%0d), expected 7",
               second - first, first, second);
    end
    checks++;
    if (gif.revealMask !== 5'b00101 || gif.lastHit !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2bSecond: got mask=%b hit=%b, expected 00101 1", gif.revealMask, gif.lastHit);
    end
  endtask

  task automatic test_reset_mid_scan();
    startLevel(WORD_CABLE);
    doGuess(5'd1, 5'b00010, 3'd0, 1'b1, 1'b0);
    doGuess(5'd26, 5'b00010, 3'd1, 1'b0, 1'b0);
    gif.guessLetter = 5'd5;
    gif.guessValid  = 1'b1;
    tick();
    gif.guessValid  = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({gif.guessReady, gif.revealMask, gif.guesses, gif.lastHit, gif.resultValid, gif.levelDone} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL resetMidScan: got rdy=%b mask=%b g=%0d hit=%b rv=%b done=%b, expected all 0",
               gif.guessReady, gif.revealMask, gif.guesses, gif.lastHit, gif.resultValid, gif.levelDone);
    end
    reset      = 1'b0;
    levelStart = 1'b0;
    tick();
  endtask

  task automatic test_drop_and_restart();
    bit bad;
    startLevel(WORD_CABLE);
    doGuess(5'd1, 5'b00010, 3'd0, 1'b1, 1'b0);
    doGuess(5'd26, 5'b00010, 3'd1, 1'b0, 1'b0);
    gif.guessLetter = 5'd5;
    gif.guessValid  = 1'b1;
    tick();
    gif.guessValid  = 1'b0;
    tick();
    levelStart = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gif.resultValid !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL dropNoResult: resultValid pulsed after levelStart dropped, expected none");
    end
    checks++;
    if (gif.revealMask !== 5'b00010 || gif.guesses !== 3'd1 || gif.guessReady !== 1'b0 || gif.levelDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dropHold: got mask=%b g=%0d rdy=%b done=%b, expected 00010 1 0 0",
               gif.revealMask, gif.guesses, gif.guessReady, gif.levelDone);
    end
    startLevel(WORD_LEVEL);
    checks++;
    if (gif.revealMask !== 5'b00000 || gif.guesses !== 3'd0 || gif.lastHit !== 1'b0 || gif.guessReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restartClear: got mask=%b g=%0d hit=%b rdy=%b, expected 00000 0 0 1",
               gif.revealMask, gif.guesses, gif.lastHit, gif.guessReady);
    end
    doGuess(5'd5, 5'b01010, 3'd0, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hit();
    test_miss_saturate();
    test_zero_guess();
    test_multi_done();
    test_back_to_back();
    test_reset_mid_scan();
    test_drop_and_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
